// File: rtl/i2c_eeprom_rw_ctrl_pkg.sv
// Shared types and constants for the EEPROM write/read-back sequencer and its I2C driver.
// FSM encoding, transfer direction, acknowledge polarity and the cycle-timer width.
package i2c_eeprom_rw_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_WAIT = 3'd2,
        WR_GAP  = 3'd3,
        RD_REQ  = 3'd4,
        RD_WAIT = 3'd5,
        FINISH  = 3'd6
    } state_t;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    // i2c_ack carries the NACK flag: 1 means the slave refused a byte.
    localparam logic ACK_OK   = 1'b0;
    localparam logic ACK_NACK = 1'b1;

    // Wide enough for both the write-cycle gap and the transaction timeout.
    localparam int TMR_W = 20;

endpackage

// File: rtl/i2c_eeprom_rw_ctrl_if.sv
// Exec/done handshake between the sequencer (master) and the I2C byte driver (slave).
interface i2c_eeprom_rw_ctrl_if;

    logic        i2c_exec;
    logic        i2c_rh_wl;
    logic [15:0] i2c_addr;
    logic [7:0]  i2c_data_w;
    logic [7:0]  i2c_data_r;
    logic        i2c_done;
    logic        i2c_ack;

    modport master (
        output i2c_exec, i2c_rh_wl, i2c_addr, i2c_data_w,
        input  i2c_data_r, i2c_done, i2c_ack
    );

    modport slave (
        input  i2c_exec, i2c_rh_wl, i2c_addr, i2c_data_w,
        output i2c_data_r, i2c_done, i2c_ack
    );

endinterface

// File: rtl/i2c_eeprom_rw_ctrl_cyc_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module i2c_eeprom_rw_ctrl_cyc_timer
    import i2c_eeprom_rw_ctrl_pkg::*;
(
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             expired
);

    logic [TMR_W-1:0] count;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - TMR_W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/i2c_eeprom_rw_ctrl.sv
// Writes BYTE_NUM bytes (data = offset) from START_ADDR, reads them back and compares,
// one single-byte I2C transaction per exec/done handshake; reports pass/fail and first bad address.
module i2c_eeprom_rw_ctrl
    import i2c_eeprom_rw_ctrl_pkg::*;
#(
    parameter logic [15:0] START_ADDR  = 16'h0000,
    parameter logic [8:0]  BYTE_NUM    = 9'd256,
    parameter logic [17:0] WR_GAP_CYC  = 18'd250000,
    parameter logic [19:0] TIMEOUT_CYC = 20'd100000
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  start,
    i2c_eeprom_rw_ctrl_if.master  bus,
    output logic                  busy,
    output logic                  rw_done,
    output logic                  rw_pass,
    output logic [15:0]           err_addr
);

    localparam logic [8:0]       LAST_OFF = BYTE_NUM - 9'd1;
    // Loading N-1 makes WR_GAP last exactly WR_GAP_CYC cycles.
    localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(WR_GAP_CYC) - TMR_W'(1);
    localparam logic [TMR_W-1:0] TO_LOAD  = TMR_W'(TIMEOUT_CYC);

    state_t           state, state_nxt;
    logic [8:0]       offset, offset_nxt;
    logic             last;
    logic             tmr_load, tmr_expired;
    logic [TMR_W-1:0] tmr_val;
    logic             offset_clr, offset_inc;
    logic             run_start, fail, pass_set;

    i2c_eeprom_rw_ctrl_cyc_timer u_timer (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    assign last         = (offset == LAST_OFF);
    assign bus.i2c_exec = (state == WR_REQ) || (state == RD_REQ);
    assign rw_done      = (state == FINISH);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        tmr_load   = 1'b0;
        tmr_val    = TO_LOAD;
        offset_clr = 1'b0;
        offset_inc = 1'b0;
        run_start  = 1'b0;
        fail       = 1'b0;
        pass_set   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    run_start  = 1'b1;
                    offset_clr = 1'b1;
                    state_nxt  = WR_REQ;
                end
            end
            WR_REQ: begin
                tmr_load  = 1'b1;
                state_nxt = WR_WAIT;
            end
            WR_WAIT: begin
                // A done arriving together with the timeout takes priority.
                if (bus.i2c_done) begin
                    if (bus.i2c_ack == ACK_NACK) begin
                        fail = 1'b1;
                    end else begin
                        tmr_load  = 1'b1;
                        tmr_val   = GAP_LOAD;
                        state_nxt = WR_GAP;
                    end
                end else if (tmr_expired) begin
                    fail = 1'b1;
                end
            end
            WR_GAP: begin
                if (tmr_expired) begin
                    if (last) begin
                        offset_clr = 1'b1;
                        state_nxt  = RD_REQ;
                    end else begin
                        offset_inc = 1'b1;
                        state_nxt  = WR_REQ;
                    end
                end
            end
            RD_REQ: begin
                tmr_load  = 1'b1;
                state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                if (bus.i2c_done) begin
                    if ((bus.i2c_ack == ACK_NACK) || (bus.i2c_data_r != offset[7:0])) begin
                        fail = 1'b1;
                    end else if (last) begin
                        pass_set  = 1'b1;
                        state_nxt = FINISH;
                    end else begin
                        offset_inc = 1'b1;
                        state_nxt  = RD_REQ;
                    end
                end else if (tmr_expired) begin
                    fail = 1'b1;
                end
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (fail) begin
            state_nxt = FINISH;
        end
    end

    always_comb begin
        offset_nxt = offset;
        if (offset_clr) begin
            offset_nxt = '0;
        end else if (offset_inc) begin
            offset_nxt = offset + 9'd1;
        end
    end

    // Address, direction and write data are latched on entry to a request state
    // so they stay stable for the whole transaction.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            offset         <= '0;
            busy           <= 1'b0;
            rw_pass        <= 1'b0;
            err_addr       <= '0;
            bus.i2c_addr   <= '0;
            bus.i2c_data_w <= '0;
            bus.i2c_rh_wl  <= RW_WRITE;
        end else begin
            offset <= offset_nxt;
            if (run_start) begin
                busy     <= 1'b1;
                rw_pass  <= 1'b0;
                err_addr <= '0;
            end
            if (state == FINISH) begin
                busy <= 1'b0;
            end
            if (pass_set) begin
                rw_pass <= 1'b1;
            end
            if (fail) begin
                err_addr <= bus.i2c_addr;
            end
            if (state_nxt == WR_REQ) begin
                bus.i2c_addr   <= START_ADDR + 16'(offset_nxt);
                bus.i2c_data_w <= offset_nxt[7:0];
                bus.i2c_rh_wl  <= RW_WRITE;
            end else if (state_nxt == RD_REQ) begin
                bus.i2c_addr  <= START_ADDR + 16'(offset_nxt);
                bus.i2c_rh_wl <= RW_READ;
            end
        end
    end

endmodule

// File: tb/tb_i2c_eeprom_rw_ctrl.sv
// Directed bench: EEPROM responder model behind the handshake, wrap-around start address.
module tb_i2c_eeprom_rw_ctrl;

    localparam int LAT = 3;

    logic        clk;
    logic        rst;
    logic        start;
    logic        busy;
    logic        rw_done;
    logic        rw_pass;
    logic [15:0] err_addr;

    i2c_eeprom_rw_ctrl_if bus ();

    i2c_eeprom_rw_ctrl #(
        .START_ADDR  (16'hFFFE),
        .BYTE_NUM    (9'd4),
        .WR_GAP_CYC  (18'd100),
        .TIMEOUT_CYC (20'd50)
    ) dut (
        .sys_clk  (clk),
        .sys_rst  (rst),
        .start    (start),
        .bus      (bus.master),
        .busy     (busy),
        .rw_done  (rw_done),
        .rw_pass  (rw_pass),
        .err_addr (err_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    // Responder knobs, set by the directed sequence.
    bit          resp_on     = 1'b1;
    bit          nack_writes = 1'b0;
    bit          bad_en      = 1'b0;
    logic [15:0] bad_addr    = 16'h0000;

    // Responder observations.
    int          cyc = 0;
    int          exec_cnt = 0;
    int          exec_cyc = 0;
    int          resp_done_cyc = 0;
    logic [15:0] log_addr [$];
    logic        log_rw   [$];
    logic [7:0]  log_data [$];
    logic [7:0]  mem [0:65535];

    initial begin
        bit          pend;
        int          cnt;
        logic        p_rw;
        logic [15:0] p_addr;
        logic [7:0]  p_data;
        pend = 1'b0;
        cnt  = 0;
        p_rw = 1'b0;
        p_addr = '0;
        p_data = '0;
        bus.i2c_done   = 1'b0;
        bus.i2c_ack    = 1'b0;
        bus.i2c_data_r = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            cyc = cyc + 1;
            bus.i2c_done   = 1'b0;
            bus.i2c_ack    = 1'b0;
            bus.i2c_data_r = 8'h00;
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    if (cnt == 0) begin
                        pend = 1'b0;
                        if (resp_on) begin
                            bus.i2c_done  = 1'b1;
                            resp_done_cyc = cyc;
                            if (p_rw) begin
                                bus.i2c_data_r = (bad_en && p_addr == bad_addr) ? 8'hFF : mem[p_addr];
                            end else begin
                                mem[p_addr] = p_data;
                                bus.i2c_ack = nack_writes;
                            end
                        end
                    end else begin
                        cnt = cnt - 1;
                    end
                end
                if (bus.i2c_exec) begin
                    exec_cnt = exec_cnt + 1;
                    exec_cyc = cyc;
                    p_rw   = bus.i2c_rh_wl;
                    p_addr = bus.i2c_addr;
                    p_data = bus.i2c_data_w;
                    log_addr.push_back(p_addr);
                    log_rw.push_back(p_rw);
                    log_data.push_back(p_data);
                    pend = 1'b1;
                    cnt  = LAT - 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks = checks + 1;
        assert (observed === expected) else begin
            failures = failures + 1;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic clear_log();
        exec_cnt = 0;
        log_addr.delete();
        log_rw.delete();
        log_data.delete();
    endtask

    // Leaves the caller at the negedge where rw_done is high.
    task automatic wait_rw_done(input string tag, input int budget, output int done_cyc);
        bit seen;
        seen = 1'b0;
        done_cyc = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rw_done === 1'b1) begin
                seen = 1'b1;
                done_cyc = cyc;
                break;
            end
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        int dc;
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_exec",     32'(bus.i2c_exec),   32'd0);
        check("rst_busy",     32'(busy),           32'd0);
        check("rst_rw_done",  32'(rw_done),        32'd0);
        check("rst_rw_pass",  32'(rw_pass),        32'd0);
        check("rst_err_addr", 32'(err_addr),       32'd0);
        check("rst_addr",     32'(bus.i2c_addr),   32'd0);
        check("rst_data_w",   32'(bus.i2c_data_w), 32'd0);
        check("rst_rh_wl",    32'(bus.i2c_rh_wl),  32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Full passing run with address wrap FFFE..0001.
        clear_log();
        pulse_start();
        check("run1_busy_early", 32'(busy),         32'd1);
        check("run1_exec_early", 32'(bus.i2c_exec), 32'd1);
        check("run1_addr_early", 32'(bus.i2c_addr), 32'hFFFE);
        wait_rw_done("run1_done_seen", 2000, dc);
        check("run1_pass",     32'(rw_pass),  32'd1);
        check("run1_err_addr", 32'(err_addr), 32'd0);
        check("run1_execs",    32'(exec_cnt), 32'd8);
        check("run1_w1_addr",  32'(log_addr[1]), 32'hFFFF);
        check("run1_w2_addr",  32'(log_addr[2]), 32'h0000);
        check("run1_w3_data",  32'(log_data[3]), 32'h03);
        check("run1_w3_rw",    32'(log_rw[3]),   32'd0);
        check("run1_r0_addr",  32'(log_addr[4]), 32'hFFFE);
        check("run1_r0_rw",    32'(log_rw[4]),   32'd1);
        check("run1_r3_addr",  32'(log_addr[7]), 32'h0001);
        check("run1_mem0000",  32'(mem[16'h0000]), 32'h02);
        @(negedge clk);
        check("run1_busy_after", 32'(busy),    32'd0);
        check("run1_done_pulse", 32'(rw_done), 32'd0);
        check("run1_pass_hold",  32'(rw_pass), 32'd1);

        // Corrupted read at offset 1 (address FFFF).
        clear_log();
        bad_en   = 1'b1;
        bad_addr = 16'hFFFF;
        pulse_start();
        check("run2_pass_cleared", 32'(rw_pass), 32'd0);
        wait_rw_done("run2_done_seen", 2000, dc);
        check("run2_pass",     32'(rw_pass),  32'd0);
        check("run2_err_addr", 32'(err_addr), 32'hFFFF);
        repeat (10) @(negedge clk);
        check("run2_execs",    32'(exec_cnt), 32'd6);
        bad_en = 1'b0;

        // NACK on the first write.
        clear_log();
        nack_writes = 1'b1;
        pulse_start();
        wait_rw_done("run3_done_seen", 200, dc);
        check("run3_finish_lat", 32'(dc - resp_done_cyc), 32'd1);
        check("run3_pass",       32'(rw_pass),  32'd0);
        check("run3_err_addr",   32'(err_addr), 32'hFFFE);
        repeat (5) @(negedge clk);
        check("run3_execs",      32'(exec_cnt), 32'd1);
        nack_writes = 1'b0;

        // Responder silent: transaction timeout.
        clear_log();
        resp_on = 1'b0;
        pulse_start();
        wait_rw_done("run4_done_seen", 200, dc);
        check("run4_timeout_lat", 32'(dc - exec_cyc), 32'd52);
        check("run4_pass",        32'(rw_pass),  32'd0);
        check("run4_err_addr",    32'(err_addr), 32'hFFFE);
        check("run4_execs",       32'(exec_cnt), 32'd1);
        resp_on = 1'b1;

        // Start while busy, then reset during the write gap.
        clear_log();
        pulse_start();
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("run5_execs_busy", 32'(exec_cnt), 32'd1);
        check("run5_busy",       32'(busy),     32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("run5_rst_busy",     32'(busy),           32'd0);
        check("run5_rst_exec",     32'(bus.i2c_exec),   32'd0);
        check("run5_rst_rw_done",  32'(rw_done),        32'd0);
        check("run5_rst_addr",     32'(bus.i2c_addr),   32'd0);
        check("run5_rst_rh_wl",    32'(bus.i2c_rh_wl),  32'd0);
        check("run5_rst_err_addr", 32'(err_addr),       32'd0);
        rst = 1'b0;
        repeat (150) @(negedge clk);
        check("run5_no_exec_idle", 32'(exec_cnt), 32'd1);
        pulse_start();
        wait_rw_done("run5_done_seen", 2000, dc);
        check("run5_pass",  32'(rw_pass),  32'd1);
        check("run5_execs", 32'(exec_cnt), 32'd9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
